// File: rtl/core_inst_sequencer_if.sv
// Job/status/instruction bundle between a host (master) and the instruction sequencer (slave).
// start is a one-cycle request with no ready: it is accepted only on a cycle where busy is low.
interface core_inst_sequencer_if #(
    parameter int addr_w = 11
);
    logic              start;
    logic [addr_w-1:0] w_base;
    logic [addr_w-1:0] x_base;
    logic [6:0]        n_x;
    logic [addr_w-1:0] p_base;
    logic              acc_en;
    logic [4:0]        status;
    logic [33:0]       inst;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, w_base, x_base, n_x, p_base, acc_en, status,
        input  inst, busy, done, err
    );

    modport slave (
        input  start, w_base, x_base, n_x, p_base, acc_en, status,
        output inst, busy, done, err
    );
endinterface

// File: rtl/core_inst_sequencer.sv
// Drives the core's 34-bit instruction word through kernel load, activation execute and OFIFO drain.
// Every output, inst included, is computed from next-state values and registered.
module core_inst_sequencer #(
    parameter int row    = 8,
    parameter int col    = 8,
    parameter int addr_w = 11,
    parameter int max_x  = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    core_inst_sequencer_if.slave bus,
    output logic [2:0]           dbg_state_o
);
    localparam int          CW        = $clog2(max_x + row + col + 1);
    localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;

    typedef enum logic [2:0] {
        S_IDLE, S_WRD, S_WLD, S_FLUSH1, S_XRD, S_EXE, S_DRAIN, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     k_q, k_d, nx_q, nx_d;
    logic [CW-1:0]     rcnt_q, rcnt_d, wcnt_q, wcnt_d, j_q, j_d;
    logic [addr_w-1:0] w_q, w_d, x_q, x_d, p_q, p_d;
    logic              acc_q, acc_d, rd_q, rd_d, wr_q, wr_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [33:0]       inst_q, inst_d;
    logic [6:0]        n_lim;
    logic              unused_status;

    assign unused_status = &{1'b0, bus.status[3:2], bus.status[0]};

    always_comb begin
        n_lim = bus.n_x;
        if (bus.n_x == 7'd0)
            n_lim = 7'd1;
        else if (bus.n_x > 7'(max_x))
            n_lim = 7'(max_x);
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        nx_d    = nx_q;
        w_d     = w_q;
        x_d     = x_q;
        p_d     = p_q;
        acc_d   = acc_q;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        rcnt_d  = rcnt_q;
        wcnt_d  = wcnt_q;
        j_d     = j_q;
        // Overflow is judged against the l0_wr actually on the bus this cycle.
        err_d   = err_q | (inst_q[2] & bus.status[1]);

        case (state_q)
            S_IDLE: if (bus.start) begin
                nx_d    = CW'(n_lim);
                w_d     = bus.w_base;
                x_d     = bus.x_base;
                p_d     = bus.p_base;
                acc_d   = bus.acc_en;
                err_d   = 1'b0;
                k_d     = '0;
                state_d = S_WRD;
            end
            S_WRD: begin
                k_d = k_q + CW'(1);
                if (k_q == CW'(row)) begin k_d = '0; state_d = S_WLD; end
            end
            S_WLD: begin
                k_d = k_q + CW'(1);
                if (k_q == CW'(row - 1)) begin k_d = '0; state_d = S_FLUSH1; end
            end
            S_FLUSH1: begin
                k_d = k_q + CW'(1);
                if (k_q == CW'(row + col - 1)) begin k_d = '0; state_d = S_XRD; end
            end
            S_XRD: begin
                k_d = k_q + CW'(1);
                if (k_q == nx_q) begin k_d = '0; state_d = S_EXE; end
            end
            S_EXE: begin
                k_d = k_q + CW'(1);
                if (k_q == nx_q - CW'(1)) begin
                    k_d     = '0;
                    rcnt_d  = '0;
                    wcnt_d  = '0;
                    j_d     = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // A read seen this cycle becomes the PMEM write of the next one.
                rd_d   = bus.status[4] && (rcnt_q < nx_q);
                rcnt_d = rcnt_q + CW'(rd_d);
                wr_d   = rd_q;
                j_d    = wcnt_q;
                wcnt_d = wcnt_q + CW'(rd_q);
                if (wr_q && (j_q == nx_q - CW'(1))) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        inst_d = IDLE_INST;
        if (state_d != S_IDLE)
            inst_d[33] = acc_d;
        case (state_d)
            S_WRD: begin
                if (k_d < CW'(row)) begin
                    inst_d[19]   = 1'b0;
                    inst_d[17:7] = w_d + addr_w'(k_d);
                end
                inst_d[2] = (k_d != '0);
            end
            S_WLD: begin
                inst_d[3] = 1'b1;
                inst_d[0] = 1'b1;
            end
            S_XRD: begin
                if (k_d < nx_d) begin
                    inst_d[19]   = 1'b0;
                    inst_d[17:7] = x_d + addr_w'(k_d);
                end
                inst_d[2] = (k_d != '0);
            end
            S_EXE: begin
                inst_d[3] = 1'b1;
                inst_d[1] = 1'b1;
            end
            S_DRAIN: begin
                inst_d[6] = rd_d;
                if (wr_d) begin
                    inst_d[32]    = 1'b0;
                    inst_d[31]    = 1'b0;
                    inst_d[30:20] = p_d + addr_w'(j_d);
                end
            end
            default: ;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            nx_q    <= '0;
            rcnt_q  <= '0;
            wcnt_q  <= '0;
            j_q     <= '0;
            w_q     <= '0;
            x_q     <= '0;
            p_q     <= '0;
            acc_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            inst_q  <= IDLE_INST;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            nx_q    <= nx_d;
            rcnt_q  <= rcnt_d;
            wcnt_q  <= wcnt_d;
            j_q     <= j_d;
            w_q     <= w_d;
            x_q     <= x_d;
            p_q     <= p_d;
            acc_q   <= acc_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            inst_q  <= inst_d;
        end
    end

    assign bus.inst    = inst_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_core_inst_sequencer.sv
// Directed jobs against core_inst_sequencer; a negedge monitor collects the instruction stream.
module tb_core_inst_sequencer;
    localparam int          ROW  = 8;
    localparam int          COL  = 8;
    localparam int          AW   = 11;
    localparam int          MAXX = 64;
    localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;
    localparam logic [2:0]  ST_IDLE  = 3'd0;
    localparam logic [2:0]  ST_XRD   = 3'd4;
    localparam logic [2:0]  ST_EXE   = 3'd5;
    localparam logic [2:0]  ST_DRAIN = 3'd6;

    // clock / reset
    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] dbg_state;
    always #5 clk = ~clk;

    core_inst_sequencer_if #(.addr_w(AW)) bus();

    core_inst_sequencer #(.row(ROW), .col(COL), .addr_w(AW), .max_x(MAXX)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // status driver: ofifo valid tied high or toggling; l0 full forced during XRD on request
    bit throttle_en = 0;
    bit ovf_en      = 0;
    bit tog         = 1;
    always @(posedge clk) begin
        logic [4:0] st;
        #1;
        st    = 5'b0;
        st[4] = throttle_en ? tog : 1'b1;
        st[1] = ovf_en && (dbg_state == ST_XRD);
        tog   = ~tog;
        bus.status = st;
    end

    // scoreboard
    logic [AW-1:0] exp_x_q[$], got_x_q[$], exp_p_q[$], got_p_q[$];
    int   n_load, n_exec, n_l0wr, n_done, n_busy, n_orphan, n_missing, n_acc_bad, n_idle_bad, n_fifo_bad;
    logic prev_rd = 1'b0;
    logic acc_exp = 1'b0;

    always @(negedge clk) begin : monitor
        logic [33:0] i;
        i = bus.inst;
        if (!reset) begin
            if (!i[19]) got_x_q.push_back(i[17:7]);
            if (!i[32] && !i[31]) begin
                got_p_q.push_back(i[30:20]);
                if (!prev_rd) n_orphan++;
            end else if (prev_rd) begin
                n_missing++;
            end
            prev_rd = i[6];
            if (i[0]) n_load++;
            if (i[1]) n_exec++;
            if (i[2]) n_l0wr++;
            if (i[5:4] != 2'b00) n_fifo_bad++;
            if (bus.done) n_done++;
            if (bus.busy) begin
                n_busy++;
                if (i[33] !== acc_exp) n_acc_bad++;
            end else if (i !== IDLE_INST) begin
                n_idle_bad++;
            end
        end
    end

    task automatic clear_mon();
        got_x_q.delete(); got_p_q.delete(); exp_x_q.delete(); exp_p_q.delete();
        n_load = 0; n_exec = 0; n_l0wr = 0; n_done = 0; n_busy = 0;
        n_orphan = 0; n_missing = 0; n_acc_bad = 0; n_idle_bad = 0; n_fifo_bad = 0;
        prev_rd = 1'b0;
    endtask

    task automatic drive_start(input logic [AW-1:0] w, input logic [AW-1:0] x,
                               input logic [AW-1:0] p, input logic [6:0] n, input logic acc);
        @(negedge clk);
        bus.w_base = w; bus.x_base = x; bus.p_base = p; bus.n_x = n; bus.acc_en = acc;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    task automatic run_job(input string name, input logic [AW-1:0] w, input logic [AW-1:0] x,
                           input logic [AW-1:0] p, input logic [6:0] n, input logic acc,
                           input bit throttle, input bit ovf, input bit poke, input bit exp_err);
        int ne;
        bit timed_out;
        bit poked;
        ne = (n == 0) ? 1 : (n > MAXX) ? MAXX : int'(n);
        clear_mon();
        acc_exp     = acc;
        throttle_en = throttle;
        ovf_en      = ovf;
        for (int k = 0; k < ROW; k++) exp_x_q.push_back(w + AW'(k));
        for (int k = 0; k < ne; k++) begin
            exp_x_q.push_back(x + AW'(k));
            exp_p_q.push_back(p + AW'(k));
        end
        drive_start(w, x, p, n, acc);
        timed_out = 1;
        poked     = 0;
        for (int c = 0; c < 5000; c++) begin
            if (!bus.busy) begin timed_out = 0; break; end
            @(negedge clk);
            bus.start = 1'b0;
            if (poke && !poked && dbg_state == ST_DRAIN) begin
                bus.start  = 1'b1;
                bus.w_base = w + AW'(300);
                bus.x_base = x + AW'(300);
                bus.p_base = p + AW'(300);
                bus.n_x    = 7'd3;
                bus.acc_en = ~acc;
                poked      = 1;
            end
        end
        bus.start = 1'b0;
        check({name, "_timeout"}, timed_out, 0);
        check({name, "_x_count"}, got_x_q.size(), exp_x_q.size());
        for (int k = 0; k < got_x_q.size() && k < exp_x_q.size(); k++)
            check($sformatf("%s_xaddr%0d", name, k), got_x_q[k], exp_x_q[k]);
        check({name, "_p_count"}, got_p_q.size(), exp_p_q.size());
        for (int k = 0; k < got_p_q.size() && k < exp_p_q.size(); k++)
            check($sformatf("%s_paddr%0d", name, k), got_p_q[k], exp_p_q[k]);
        check({name, "_load_cycles"}, n_load, ROW);
        check({name, "_exec_cycles"}, n_exec, ne);
        check({name, "_l0wr_cycles"}, n_l0wr, ROW + ne);
        check({name, "_done_pulses"}, n_done, 1);
        check({name, "_orphan_writes"}, n_orphan, 0);
        check({name, "_missing_writes"}, n_missing, 0);
        check({name, "_acc_bit"}, n_acc_bad, 0);
        check({name, "_fifo_bits"}, n_fifo_bad, 0);
        check({name, "_err"}, bus.err, exp_err);
        if (!throttle)
            check({name, "_busy_len"}, n_busy, (ROW + 1) + ROW + (ROW + COL) + (ne + 1) + ne + (ne + 2) + 1);
        if (poke) begin
            check({name, "_poke_seen"}, poked, 1);
            repeat (3) @(negedge clk);
            check({name, "_no_restart"}, bus.busy, 0);
        end
        check({name, "_idle_inst"}, bus.inst, IDLE_INST);
        check({name, "_idle_cycles"}, n_idle_bad, 0);
        ovf_en = 0;
    endtask

    initial begin
        bit reached;
        reset = 1'b1;
        bus.start = 1'b0; bus.w_base = '0; bus.x_base = '0; bus.p_base = '0;
        bus.n_x = '0; bus.acc_en = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_inst", bus.inst, IDLE_INST);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err",  bus.err, 0);
        check("rst_state", dbg_state, ST_IDLE);

        // reset mid-EXE after an overflow has set err
        ovf_en = 1;
        drive_start(11'd0, 11'd16, 11'd100, 7'd36, 1'b1);
        reached = 0;
        for (int c = 0; c < 500; c++) begin
            if (dbg_state == ST_EXE) begin reached = 1; break; end
            @(negedge clk);
        end
        check("midexe_reached", reached, 1);
        repeat (3) @(negedge clk);
        check("midexe_err_set", bus.err, 1);
        check("midexe_busy", bus.busy, 1);
        #2 reset = 1'b1;
        #1;
        check("abort_inst", bus.inst, IDLE_INST);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_err",  bus.err, 0);
        check("abort_state", dbg_state, ST_IDLE);
        ovf_en = 0;
        @(negedge clk);
        reset = 1'b0;

        run_job("basic",   11'd0,    11'd16,   11'd100,  7'd36,  1'b0, 0, 0, 0, 0);
        run_job("throt",   11'd0,    11'd16,   11'd100,  7'd36,  1'b0, 1, 0, 0, 0);
        run_job("wrap",    11'd2044, 11'd2045, 11'd2040, 7'd10,  1'b0, 0, 0, 0, 0);
        run_job("ovf",     11'd32,   11'd64,   11'd500,  7'd12,  1'b0, 0, 1, 0, 1);
        run_job("poke",    11'd8,    11'd200,  11'd7,    7'd20,  1'b1, 0, 0, 1, 0);
        run_job("nx_zero", 11'd1,    11'd2,    11'd3,    7'd0,   1'b0, 0, 0, 0, 0);
        run_job("nx_clamp",11'd100,  11'd1000, 11'd2000, 7'd100, 1'b1, 1, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
